// File: rtl/sc2110_align_ctrl.sv
// sc2110_align_ctrl: word-alignment training controller for one SC2110 LVDS lane.
// Hunts for the FFF,000,000,<code> sync preamble, issues bitslips until codes land on
// the word boundary, confirms over LOCK_CNT sync events, then watches for loss of lock.
module sc2110_align_ctrl #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned SEARCH_WIN = 4096,
  parameter int unsigned SLIP_WAIT  = 4,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned LOSS_CNT   = 4,
  parameter int unsigned MAX_SLIP   = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_dvld,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_bitslip,
  output logic              o_aligned,
  output logic              o_train_fail,
  output logic [3:0]        o_slip_cnt,
  output logic [2:0]        o_state
);

  localparam int unsigned WC_W = $clog2(SEARCH_WIN + 1);
  localparam int unsigned WT_W = $clog2(SLIP_WAIT + 1);
  localparam int unsigned GD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MS_W = $clog2(LOSS_CNT + 1);

  localparam logic [DATA_W-1:0] CODE_A = DATA_W'(12'h800);
  localparam logic [DATA_W-1:0] CODE_B = DATA_W'(12'h9D0);
  localparam logic [DATA_W-1:0] CODE_C = DATA_W'(12'hAB0);
  localparam logic [DATA_W-1:0] CODE_D = DATA_W'(12'hB60);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_SLIP    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CONFIRM = 3'd4,
    ST_LOCKED  = 3'd5,
    ST_FAIL    = 3'd6
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] hist [3];
  logic [WC_W-1:0]   wcnt, wcnt_nxt;
  logic [WT_W-1:0]   wt, wt_nxt;
  logic [GD_W-1:0]   good, good_nxt;
  logic [MS_W-1:0]   miss, miss_nxt;
  logic [3:0]        slip, slip_nxt;
  logic              pre, code_ok, sync, cerr, expiry, counting;

  // Preamble detector and window-expiry qualification for the current word
  always_comb begin
    pre     = (hist[0] == '1) && (hist[1] == '0) && (hist[2] == '0);
    code_ok = i_data inside {CODE_A, CODE_B, CODE_C, CODE_D};
    sync    = i_dvld && pre && code_ok;
    cerr    = i_dvld && pre && !code_ok;
    expiry  = i_dvld && !sync && (wcnt == WC_W'(SEARCH_WIN - 1));
  end

  // Next-state and counter update
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = i_dvld ? wcnt + WC_W'(1) : wcnt;
    wt_nxt    = wt;
    good_nxt  = good;
    miss_nxt  = miss;
    slip_nxt  = slip;
    counting  = 1'b0;
    case (state)
      ST_IDLE: begin
        good_nxt = '0;
        miss_nxt = '0;
        slip_nxt = '0;
        wt_nxt   = '0;
        if (i_en) state_nxt = ST_SEARCH;
      end
      ST_SEARCH: begin
        counting = 1'b1;
        if (sync) begin
          state_nxt = ST_CONFIRM;
          good_nxt  = GD_W'(1);
        end else if (expiry) begin
          good_nxt = '0;
          if (slip == 4'(MAX_SLIP)) state_nxt = ST_FAIL;
          else begin
            state_nxt = ST_SLIP;
            slip_nxt  = slip + 4'd1;
          end
        end
      end
      ST_SLIP: begin
        state_nxt = ST_WAIT;
        wt_nxt    = '0;
      end
      ST_WAIT: begin
        if (wt == WT_W'(SLIP_WAIT - 1)) state_nxt = ST_SEARCH;
        else wt_nxt = wt + WT_W'(1);
      end
      ST_CONFIRM: begin
        counting = 1'b1;
        if (sync) begin
          if (good == GD_W'(LOCK_CNT - 1)) state_nxt = ST_LOCKED;
          good_nxt = good + GD_W'(1);
        end else if (cerr || expiry) begin
          good_nxt = '0;
          if (slip == 4'(MAX_SLIP)) state_nxt = ST_FAIL;
          else begin
            state_nxt = ST_SLIP;
            slip_nxt  = slip + 4'd1;
          end
        end
      end
      ST_LOCKED: begin
        counting = 1'b1;
        if (sync) miss_nxt = '0;
        else if (cerr || expiry) begin
          if (miss == MS_W'(LOSS_CNT - 1)) begin
            state_nxt = ST_SEARCH;
            slip_nxt  = '0;
            good_nxt  = '0;
            miss_nxt  = '0;
          end else miss_nxt = miss + MS_W'(1);
        end
      end
      default: ;
    endcase
    // The word counter restarts on every sync, every expiry and every state entry
    if (sync || expiry || !counting || (state_nxt != state)) wcnt_nxt = '0;
    if (!i_en) begin
      state_nxt = ST_IDLE;
      wcnt_nxt  = '0;
      wt_nxt    = '0;
      good_nxt  = '0;
      miss_nxt  = '0;
      slip_nxt  = '0;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      wcnt         <= '0;
      wt           <= '0;
      good         <= '0;
      miss         <= '0;
      slip         <= '0;
      o_bitslip    <= 1'b0;
      o_aligned    <= 1'b0;
      o_train_fail <= 1'b0;
    end else begin
      state        <= state_nxt;
      wcnt         <= wcnt_nxt;
      wt           <= wt_nxt;
      good         <= good_nxt;
      miss         <= miss_nxt;
      slip         <= slip_nxt;
      o_bitslip    <= (state_nxt == ST_SLIP);
      o_aligned    <= (state_nxt == ST_LOCKED);
      o_train_fail <= (state_nxt == ST_FAIL);
    end
  end

  // Word history: cleared while settling after a slip, otherwise shifts on valid words
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hist[0] <= '0;
      hist[1] <= '0;
      hist[2] <= '0;
    end else if (state_nxt == ST_WAIT) begin
      hist[0] <= '0;
      hist[1] <= '0;
      hist[2] <= '0;
    end else if (i_dvld && (state != ST_WAIT)) begin
      hist[0] <= hist[1];
      hist[1] <= hist[2];
      hist[2] <= i_data;
    end
  end

  assign o_slip_cnt = slip;
  assign o_state    = state;

endmodule

// File: tb/tb_sc2110_align_ctrl.sv
// tb_sc2110_align_ctrl: directed bench for the lane alignment controller, with a
// simple SERDES model that rotates word alignment by one bit per bitslip pulse.
module tb_sc2110_align_ctrl;

  localparam int unsigned SW = 64;
  localparam int unsigned SLIP_WAIT = 4;

  logic        i_clk = 1'b0;
  logic        i_rst, i_en, i_dvld;
  logic [11:0] i_data;
  logic        o_bitslip, o_aligned, o_train_fail;
  logic [3:0]  o_slip_cnt;
  logic [2:0]  o_state;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int pulses = 0;
  int last_cyc = -1;
  int off = 0;
  bit model_on = 1'b0;
  logic [11:0] prev_true = '0;
  logic [11:0] codes [4] = '{12'h800, 12'h9D0, 12'hAB0, 12'hB60};

  sc2110_align_ctrl #(
    .DATA_W(12), .SEARCH_WIN(SW), .SLIP_WAIT(SLIP_WAIT),
    .LOCK_CNT(4), .LOSS_CNT(4), .MAX_SLIP(12)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_dvld(i_dvld), .i_data(i_data),
    .o_bitslip(o_bitslip), .o_aligned(o_aligned), .o_train_fail(o_train_fail),
    .o_slip_cnt(o_slip_cnt), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Count bitslip pulses, check their spacing, and rotate the modelled SERDES alignment
  always @(negedge i_clk) begin
    if (o_bitslip) begin
      pulses++;
      if (last_cyc >= 0) chk("slip_gap", 32'(cyc - last_cyc >= SLIP_WAIT + 2), 1);
      last_cyc = cyc;
      if (model_on) off = (off + 11) % 12;
    end
  end

  task automatic put(input logic dv, input logic [11:0] d);
    i_dvld = dv;
    i_data = d;
    @(posedge i_clk);
    #1;
  endtask

  task automatic tick();
    put(1'b0, 12'h000);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) put(1'b1, 12'h555);
  endtask

  task automatic preamble();
    put(1'b1, 12'hFFF);
    put(1'b1, 12'h000);
    put(1'b1, 12'h000);
  endtask

  task automatic send_true(input logic [11:0] w);
    logic [23:0] cat;
    cat = {prev_true, w} >> off;
    put(1'b1, cat[11:0]);
    prev_true = w;
  endtask

  task automatic clr_slips();
    pulses = 0;
    last_cyc = -1;
  endtask

  initial begin
    int n;
    logic [11:0] w;
    i_rst = 1'b1; i_en = 1'b0; i_dvld = 1'b0; i_data = '0;
    tick(); tick();
    chk("rst_state", 32'(o_state), 0);
    chk("rst_bitslip", 32'(o_bitslip), 0);
    chk("rst_aligned", 32'(o_aligned), 0);
    chk("rst_fail", 32'(o_train_fail), 0);
    chk("rst_slipcnt", 32'(o_slip_cnt), 0);
    i_rst = 1'b0;
    tick();
    chk("idle_hold", 32'(o_state), 0);

    // Aligned stream: lock after the 4th sync, no slips
    clr_slips();
    i_en = 1'b1;
    tick();
    chk("al_search", 32'(o_state), 1);
    for (int ln = 0; ln < 4; ln++) begin
      preamble();
      if (ln == 3) begin
        chk("al_pre_lock", 32'(o_aligned), 0);
        chk("al_confirm", 32'(o_state), 4);
      end
      put(1'b1, codes[ln]);
      if (ln == 0) chk("al_first_sync", 32'(o_state), 4);
      if (ln < 3) fill(36);
    end
    chk("al_lock", 32'(o_aligned), 1);
    chk("al_locked_st", 32'(o_state), 5);
    chk("al_slipcnt", 32'(o_slip_cnt), 0);
    chk("al_pulses", 32'(pulses), 0);

    // One missed window followed by a sync keeps lock; then 4 misses drop it
    fill(SW);
    chk("miss1_keep", 32'(o_state), 5);
    preamble();
    put(1'b1, 12'hAB0);
    fill(4 * SW - 1);
    chk("loss_pre", 32'(o_aligned), 1);
    fill(1);
    chk("loss_aligned", 32'(o_aligned), 0);
    chk("loss_state", 32'(o_state), 1);
    i_en = 1'b0;
    tick();
    chk("en_off_idle", 32'(o_state), 0);

    // Code error in CONFIRM after two good syncs
    i_en = 1'b1;
    tick();
    preamble(); put(1'b1, 12'h800); fill(36);
    preamble(); put(1'b1, 12'h9D0); fill(36);
    preamble(); put(1'b1, 12'h123);
    chk("cerr_slip_st", 32'(o_state), 2);
    chk("cerr_bitslip", 32'(o_bitslip), 1);
    chk("cerr_slipcnt", 32'(o_slip_cnt), 1);
    tick();
    chk("cerr_wait", 32'(o_state), 3);
    chk("cerr_pulse_end", 32'(o_bitslip), 0);
    tick(); tick(); tick();
    chk("cerr_wait_hold", 32'(o_state), 3);
    tick();
    chk("cerr_resume", 32'(o_state), 1);
    for (int ln = 0; ln < 4; ln++) begin
      preamble();
      put(1'b1, codes[ln]);
      if (ln == 2) chk("cerr_relock_pre", 32'(o_aligned), 0);
      if (ln < 3) fill(36);
    end
    chk("cerr_relock", 32'(o_aligned), 1);
    chk("cerr_relock_cnt", 32'(o_slip_cnt), 1);
    i_en = 1'b0;
    tick();

    // Reset pulse during WAIT
    clr_slips();
    i_en = 1'b1;
    tick();
    fill(SW);
    chk("rw_slip", 32'(o_state), 2);
    tick();
    chk("rw_wait", 32'(o_state), 3);
    i_rst = 1'b1;
    #1;
    chk("rw_async", 32'(o_state), 0);
    tick();
    chk("rw_state", 32'(o_state), 0);
    chk("rw_bitslip", 32'(o_bitslip), 0);
    chk("rw_slipcnt", 32'(o_slip_cnt), 0);
    i_rst = 1'b0;

    // Enable drop during SLIP
    tick();
    fill(SW);
    chk("es_slip", 32'(o_bitslip), 1);
    i_en = 1'b0;
    tick();
    chk("es_bitslip", 32'(o_bitslip), 0);
    chk("es_state", 32'(o_state), 0);
    chk("es_slipcnt", 32'(o_slip_cnt), 0);

    // Misaligned by 5: exactly five slips, then lock
    clr_slips();
    off = 5; prev_true = '0; model_on = 1'b1;
    i_en = 1'b1;
    tick();
    n = 0;
    while (!o_aligned && n < 3000) begin
      if (n % 40 == 0) w = 12'hFFF;
      else if (n % 40 < 3) w = 12'h000;
      else if (n % 40 == 3) w = codes[(n / 40) % 4];
      else w = 12'h555;
      send_true(w);
      n++;
    end
    chk("mis_lock", 32'(o_aligned), 1);
    chk("mis_pulses", 32'(pulses), 5);
    chk("mis_slipcnt", 32'(o_slip_cnt), 5);
    model_on = 1'b0;
    i_en = 1'b0;
    tick();

    // No sync ever: 12 slips then FAIL
    clr_slips();
    i_en = 1'b1;
    tick();
    for (int i = 0; i < SW - 1; i++) put(1'b1, 12'($urandom_range(12'h001, 12'hFFE)));
    chk("ns_pre_slip", 32'(o_state), 1);
    put(1'b1, 12'h456);
    chk("ns_slip_st", 32'(o_state), 2);
    chk("ns_bitslip", 32'(o_bitslip), 1);
    chk("ns_slipcnt1", 32'(o_slip_cnt), 1);
    n = 0;
    while (!o_train_fail && n < 3000) begin
      put(1'b1, 12'($urandom_range(12'h001, 12'hFFE)));
      n++;
    end
    chk("ns_fail", 32'(o_train_fail), 1);
    chk("ns_fail_st", 32'(o_state), 6);
    chk("ns_pulses", 32'(pulses), 12);
    chk("ns_slipcnt", 32'(o_slip_cnt), 12);
    fill(10);
    chk("ns_fail_hold", 32'(o_state), 6);
    i_en = 1'b0;
    tick();
    chk("ns_idle", 32'(o_state), 0);
    chk("ns_fail_clr", 32'(o_train_fail), 0);
    i_en = 1'b1;
    tick();
    chk("ns_restart", 32'(o_state), 1);
    chk("ns_restart_cnt", 32'(o_slip_cnt), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/sc2110_align_ctrl.md
# sc2110_align_ctrl

Word-alignment training controller for the SC2110 LVDS deserializer lane. It watches the 12-bit deserialized word stream for the sensor sync preamble (FFF, 000, 000, code). It issues single-cycle bitslip pulses to the SERDES until code words appear at the correct boundary, then declares lock and monitors for loss of alignment. It sits between the SERDES deserializer and the sync-generation stage, and its aligned flag gates the downstream frame/line decoder.

## Interface
- DATA_W, 12, deserialized word width
- SEARCH_WIN, 4096, i_dvld words allowed between sync events before a miss is declared
- SLIP_WAIT, 4, clock cycles to wait after a bitslip before searching resumes
- LOCK_CNT, 4, consecutive sync events required to declare lock
- LOSS_CNT, 4, consecutive missed windows in LOCKED that force re-training
- MAX_SLIP, 12, bitslip positions tried before failure

Ports:
- i_clk  in  1  sole clock for all logic
- i_rst  in  1  asynchronous, active-high reset
- i_en  in  1  training enable; low forces IDLE
- i_dvld  in  1  qualifies i_data
- i_data  in  DATA_W  deserialized word
- o_bitslip  out  1  registered one-cycle pulse to the SERDES bitslip input
- o_aligned  out  1  high only in LOCKED
- o_train_fail  out  1  high only in FAIL
- o_slip_cnt  out  4  bitslips issued in the current training attempt
- o_state  out  3  IDLE=0, SEARCH=1, SLIP=2, WAIT=3, CONFIRM=4, LOCKED=5, FAIL=6

## Operation
- Detector: a 3-word history shifts on i_dvld only, oldest first.
  - Sync event: i_dvld=1, history = FFF,000,000, and i_data ∈ {800, 9D0, AB0, B60}.
  - Code error: the same preamble is present but i_data is outside that set.
  - The history is cleared to 0 on entry to WAIT.
- Word counter: counts i_dvld words and clears on every sync event and on every state entry. Its width is clog2(SEARCH_WIN+1).
- Window expiry: the counter reaches SEARCH_WIN. A sync event on the same word wins and clears the counter.
- IDLE: all counters are 0. When i_en=1, go to SEARCH.
- SEARCH:
  - On a sync event, go to CONFIRM with good=1.
  - On window expiry, go to FAIL if slip_cnt==MAX_SLIP, else go to SLIP.
- SLIP: lasts one cycle. o_bitslip=1 and slip_cnt++. Then go to WAIT.
- WAIT: lasts SLIP_WAIT cycles, ignoring input. Then go to SEARCH.
- CONFIRM:
  - Each sync event increments good. When good reaches LOCK_CNT, go to LOCKED.
  - A code error or window expiry takes the same exit as a SEARCH expiry (SLIP or FAIL).
- LOCKED:
  - Each sync event clears miss.
  - Each window expiry or code error increments miss.
  - When miss reaches LOSS_CNT, go to SEARCH, clearing slip_cnt, good and miss.
- FAIL: holds until i_en=0.
- i_en=0 in any state: go to IDLE on the next clock, abandoning any WAIT. This overrides all other transitions.
- slip_cnt saturates at MAX_SLIP and never wraps.

## Timing
- Reset values: o_bitslip=0, o_aligned=0, o_train_fail=0, o_slip_cnt=0, o_state=IDLE. Counters and history are all 0.
- All outputs are registered and change one clock after the triggering i_dvld edge or condition.
- o_bitslip is high for exactly one clock per slip. Consecutive pulses are separated by at least SLIP_WAIT+2 clocks.
- o_aligned rises one clock after the i_dvld word carrying the LOCK_CNT-th sync event. It falls one clock after the LOSS_CNT-th miss, or one clock after i_en falls.
- i_dvld gaps stall the detector and the word counter but not the WAIT timer.
- Reset asserted mid-training returns to IDLE immediately. No partial bitslip pulse is emitted.

## Test plan
- Aligned stream: i_en=1, lines with FFF,000,000,800 … FFF,000,000,9D0 every 100 words. Required: o_slip_cnt=0, o_bitslip never pulses, o_aligned rises one clock after the 4th sync word.
- Misaligned by 5: model the SERDES, which rotates alignment by one per bitslip. Required: exactly 5 o_bitslip pulses, each SLIP_WAIT+2 or more apart, then lock with o_slip_cnt=5.
- No sync ever (random data, SEARCH_WIN=64): required: 12 slips, then o_state=FAIL and o_train_fail=1. Lowering i_en gives o_state=IDLE the next clock; raising it restarts with o_slip_cnt=0.
- Code error in CONFIRM: preamble followed by 123 after 2 good syncs. Required: one o_bitslip, with good restarting from 0.
- Loss in LOCKED: stop sync words for 4×SEARCH_WIN words. Required: o_aligned falls one clock after the 4th expiry and o_state=SEARCH. A single missed window followed by a sync keeps lock.
- i_rst pulse during WAIT, and i_en drop during SLIP: required: all outputs at reset values and o_bitslip low on the following clock.
